// File: rtl/block_mem_responder_if.sv
// Block-transfer bus between the cache (master) and its backing memory (slave).
// Requests travel master->slave; fetched blocks and the ready flag travel back.
interface block_mem_responder_if #(
  parameter int BLOCK_W = 256
);
  logic               blockread;
  logic               blockwrite;
  logic [31:0]        instraddr;
  logic [31:0]        blockaddr;
  logic [31:0]        wbaddr;
  logic [BLOCK_W-1:0] writeblock;
  logic [BLOCK_W-1:0] readblock;
  logic [BLOCK_W-1:0] instrblock;
  logic               memready;

  modport master (
    output blockread, blockwrite, instraddr, blockaddr, wbaddr, writeblock,
    input  readblock, instrblock, memready
  );

  modport slave (
    input  blockread, blockwrite, instraddr, blockaddr, wbaddr, writeblock,
    output readblock, instrblock, memready
  );
endinterface

// File: rtl/block_mem_responder.sv
// Backing memory for the cache block interface: one request at a time, optional
// victim write-back plus instruction/data fetch, answered after LATENCY wait cycles.
module block_mem_responder #(
  parameter int BLOCK_W = 256,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  block_mem_responder_if.slave  bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  if (LATENCY < 1) begin : g_latency_check
    $error("block_mem_responder: LATENCY must be >= 1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_COMMIT} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               rd_q;
  logic               wr_q;
  logic [IDX_W-1:0]   iidx_q;
  logic [IDX_W-1:0]   bidx_q;
  logic [IDX_W-1:0]   widx_q;
  logic [BLOCK_W-1:0] wdata_q;
  logic               memready_q;
  logic [BLOCK_W-1:0] readblock_q;
  logic [BLOCK_W-1:0] instrblock_q;
  logic [BLOCK_W-1:0] readblock_d;
  logic [BLOCK_W-1:0] instrblock_d;

  logic [BLOCK_W-1:0] mem [DEPTH];

  // Upper address bits alias onto the same block and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{bus.instraddr[31:IDX_W], bus.blockaddr[31:IDX_W],
                            bus.wbaddr[31:IDX_W]};

  // Reads in COMMIT observe the write-back of the same COMMIT.
  always_comb begin
    instrblock_d = (wr_q && (widx_q == iidx_q)) ? wdata_q : mem[iidx_q];
    readblock_d  = readblock_q;
    if (rd_q) begin
      readblock_d = (wr_q && (widx_q == bidx_q)) ? wdata_q : mem[bidx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_COMMIT && wr_q) begin
      mem[widx_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      iidx_q       <= '0;
      bidx_q       <= '0;
      widx_q       <= '0;
      wdata_q      <= '0;
      memready_q   <= 1'b1;
      readblock_q  <= '0;
      instrblock_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.blockread || bus.blockwrite) begin
            rd_q       <= bus.blockread;
            wr_q       <= bus.blockwrite;
            iidx_q     <= bus.instraddr[IDX_W-1:0];
            bidx_q     <= bus.blockaddr[IDX_W-1:0];
            widx_q     <= bus.wbaddr[IDX_W-1:0];
            wdata_q    <= bus.writeblock;
            memready_q <= 1'b0;
            cnt_q      <= CNT_W'(LATENCY - 1);
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= ST_COMMIT;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_COMMIT: begin
          instrblock_q <= instrblock_d;
          readblock_q  <= readblock_d;
          memready_q   <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_IDLE;
          memready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.memready   = memready_q;
  assign bus.readblock  = readblock_q;
  assign bus.instrblock = instrblock_q;
endmodule

// File: tb/tb_block_mem_responder.sv
// Randomized scoreboard bench for block_mem_responder against an array-based memory model.
module tb_block_mem_responder;
  localparam int BW    = 256;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  block_mem_responder_if #(.BLOCK_W(BW)) bus ();

  block_mem_responder #(.BLOCK_W(BW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          chk_i;
    logic [BW-1:0] exp_i;
    bit          chk_r;
    logic [BW-1:0] exp_r;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [BW-1:0] mm [DEPTH];
  bit            known [DEPTH];
  logic [BW-1:0] m_rb;
  bit            m_rb_known;
  int            checks = 0;
  int            errors = 0;
  int            low_cnt = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/none expected response", name);
  endtask

  function automatic logic [BW-1:0] rand_blk();
    logic [BW-1:0] r;
    for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom() & ~32'(DEPTH - 1)) | 32'($urandom_range(0, 15));
    return a;
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'(a % 32'(DEPTH));
  endfunction

  // Reference: write first, then instruction fetch, then optional data fetch.
  task automatic model_req(input bit rd, input bit wr, input logic [31:0] ia,
                           input logic [31:0] ba, input logic [31:0] wa,
                           input logic [BW-1:0] wd);
    exp_t e;
    if (wr) begin
      mm[idx(wa)]    = wd;
      known[idx(wa)] = 1'b1;
    end
    e.chk_i = known[idx(ia)];
    e.exp_i = mm[idx(ia)];
    if (rd) begin
      m_rb       = mm[idx(ba)];
      m_rb_known = known[idx(ba)];
    end
    e.chk_r = m_rb_known;
    e.exp_r = m_rb;
    sb.push_back(e);
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < 50) begin
      @(negedge clk);
      if (bus.memready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    if (!ok) fail("wait_memready");
  endtask

  task automatic req(input bit rd, input bit wr, input logic [31:0] ia,
                     input logic [31:0] ba, input logic [31:0] wa,
                     input logic [BW-1:0] wd, input bit busy_pulse,
                     input logic [31:0] pa);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    bus.blockread  = rd;
    bus.blockwrite = wr;
    bus.instraddr  = ia;
    bus.blockaddr  = ba;
    bus.wbaddr     = wa;
    bus.writeblock = wd;
    model_req(rd, wr, ia, ba, wa, wd);
    @(negedge clk);
    bus.blockread  = 1'b0;
    bus.blockwrite = 1'b0;
    if (busy_pulse) begin
      bus.blockwrite = 1'b1;
      bus.wbaddr     = pa;
      bus.writeblock = rand_blk();
      @(negedge clk);
      bus.blockwrite = 1'b0;
    end
  endtask

  // Monitor: each rising memready completes one transaction.
  always @(negedge clk) begin
    if (!rst_n) begin
      low_cnt = 0;
    end else if (bus.memready !== 1'b1) begin
      low_cnt++;
    end else if (low_cnt != 0) begin
      chk_int("busy_cycles", low_cnt, LAT + 1);
      if (sb.size() == 0) begin
        fail("unexpected_response");
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk_i) chk("instrblock", bus.instrblock, mon_e.exp_i);
        if (mon_e.chk_r) chk("readblock", bus.readblock, mon_e.exp_r);
      end
      low_cnt = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] pa_blk, pb_blk, pc_blk, d7;
    bit ok;
    bit rd, wr;
    rst_n          = 1'b0;
    bus.blockread  = 1'b0;
    bus.blockwrite = 1'b0;
    bus.instraddr  = '0;
    bus.blockaddr  = '0;
    bus.wbaddr     = '0;
    bus.writeblock = '0;
    m_rb           = '0;
    m_rb_known     = 1'b1;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    repeat (3) @(negedge clk);
    chk_int("rst_memready", int'(bus.memready), 1);
    chk("rst_readblock", bus.readblock, '0);
    chk("rst_instrblock", bus.instrblock, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_int("idle_memready", int'(bus.memready), 1);
    end
    chk("idle_readblock", bus.readblock, '0);
    chk("idle_instrblock", bus.instrblock, '0);

    // write then read back
    req(0, 1, 32'd0, 32'd0, 32'd5, {8{32'hDEADBEEF}}, 0, 32'd0);
    req(1, 0, 32'd0, 32'd5, 32'd0, '0, 0, 32'd0);
    wait_ready(ok);
    chk("wr_rd_deadbeef", bus.readblock, {8{32'hDEADBEEF}});

    // combined transfer with forwarding
    pa_blk = rand_blk();
    req(0, 1, 32'd0, 32'd0, 32'd9, '1, 0, 32'd0);
    req(1, 1, 32'd9, 32'd3, 32'd3, pa_blk, 0, 32'd0);
    wait_ready(ok);
    chk("fwd_readblock", bus.readblock, pa_blk);
    chk("fwd_instrblock", bus.instrblock, '1);

    // busy-ignore
    d7 = rand_blk();
    req(0, 1, 32'd0, 32'd0, 32'd7, d7, 0, 32'd0);
    req(1, 0, 32'd0, 32'd0, 32'd0, '0, 1, 32'd7);
    req(1, 0, 32'd0, 32'd7, 32'd0, '0, 0, 32'd0);
    wait_ready(ok);
    chk("busy_ignore", bus.readblock, d7);

    // aliasing
    pb_blk = rand_blk();
    req(0, 1, 32'd0, 32'd0, 32'h105, pb_blk, 0, 32'd0);
    req(1, 0, 32'd0, 32'd5, 32'd0, '0, 0, 32'd0);
    wait_ready(ok);
    chk("alias", bus.readblock, pb_blk);

    // reset during WAIT discards the write-back
    pc_blk = rand_blk();
    req(0, 1, 32'd0, 32'd0, 32'd2, pc_blk, 0, 32'd0);
    wait_ready(ok);
    bus.blockwrite = 1'b1;
    bus.wbaddr     = 32'd2;
    bus.writeblock = rand_blk();
    bus.instraddr  = 32'd0;
    @(negedge clk);
    bus.blockwrite = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_int("midrst_memready", int'(bus.memready), 1);
    chk("midrst_readblock", bus.readblock, '0);
    chk("midrst_instrblock", bus.instrblock, '0);
    m_rb       = '0;
    m_rb_known = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    req(1, 0, 32'd0, 32'd2, 32'd0, '0, 0, 32'd0);
    wait_ready(ok);
    chk("midrst_mem", bus.readblock, pc_blk);

    // fill every block, then random traffic
    for (int i = 0; i < DEPTH; i++) begin
      req(0, 1, 32'(i), 32'd0, 32'(i), rand_blk(), 0, 32'd0);
    end
    for (int n = 0; n < 200; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      req(rd, wr, rand_addr(), rand_addr(), rand_addr(), rand_blk(),
          ($urandom_range(0, 3) == 0), rand_addr());
    end

    wait_ready(ok);
    repeat (2) @(negedge clk);
    chk_int("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/block_mem_responder.md
Name: block_mem_responder

Overview:
- Backing-memory responder for the cache's block-transfer interface; it is the memory end of blockread/blockwrite/memready.
- Holds DEPTH blocks of BLOCK_W bits.
- Accepts one request at a time: an optional dirty-victim write-back plus an instruction-block fetch and an optional data-block fetch.
- Answers after a programmable latency, with memready held low while busy.

Parameters:
- BLOCK_W, 256, block width in bits (8 instruction words / 4 dwords).
- DEPTH, 256, number of blocks stored; power of two.
- LATENCY, 2, wait cycles between acceptance and commit; must be >=1 (elaboration error otherwise).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- blockread  input  1  request a data-block fetch from blockaddr.
- blockwrite  input  1  request write-back of writeblock to wbaddr.
- instraddr  input  32  block address for the instruction fetch; serviced on every accepted request.
- blockaddr  input  32  block address for the data fetch.
- wbaddr  input  32  block address of the dirty victim being written back.
- writeblock  input  BLOCK_W  victim block data.
- readblock  output  BLOCK_W  fetched data block.
- instrblock  output  BLOCK_W  fetched instruction block.
- memready  output  1  high = idle and able to accept; low = busy.

Behaviour:
- Reset (async assert, rst_n=0):
  - memready=1; readblock=0; instrblock=0; state IDLE; counter=0; all captured request registers cleared.
  - Storage array contents are not reset.
- Address mapping: index = addr[$clog2(DEPTH)-1:0]; upper bits ignored (aliasing is legal).
- States: IDLE -> WAIT -> COMMIT -> IDLE.
- IDLE:
  - Acceptance: at any rising edge where memready=1 and (blockread | blockwrite)=1, the request is accepted.
  - Capture instraddr, blockaddr, wbaddr, writeblock, blockread, blockwrite.
  - memready<=0; counter<=LATENCY-1; go to WAIT.
- WAIT:
  - Counter decrements each cycle; inputs are ignored.
  - At counter==0, go to COMMIT.
- COMMIT (single cycle), in this order:
  1. If captured blockwrite: mem[wbaddr index] <= captured writeblock.
  2. instrblock <= mem[instraddr index].
  3. If captured blockread: readblock <= mem[blockaddr index].
  4. memready<=1; go to IDLE.
- Reads in COMMIT see the block written in the same COMMIT (write-first forwarding). If wbaddr equals instraddr or blockaddr, the new writeblock value is returned.
- readblock is unchanged when captured blockread=0. Both outputs hold until the next COMMIT.
- Latency: request accepted at edge N -> memready low from N through N+LATENCY. Data valid and memready=1 after edge N+LATENCY+1. memready is low for exactly LATENCY+1 cycles.
- The cache drives requests on negedge; setup to the following posedge is guaranteed by the interface.
- Requests while memready=0 are ignored. They are not queued and have no side effects.
- Level-held request: if blockread/blockwrite are still high in the first IDLE cycle after COMMIT, that is a new request and is accepted again. The initiator must deassert the strobes when memready is low.
- Reset mid-operation: returns to IDLE immediately with memready=1. A write-back not yet in COMMIT is discarded and memory is unchanged.
- No X propagation: outputs are driven only from registers.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then high -> memready=1, readblock=0, instrblock=0; no state change with strobes low for 10 cycles.
- Write then read (LATENCY=2):
  - blockwrite=1, wbaddr=5, writeblock={8{32'hDEADBEEF}}, instraddr=0 -> memready low exactly 3 cycles.
  - Follow with blockread=1, blockaddr=5 -> readblock={8{32'hDEADBEEF}}, memready high after 3 cycles.
- Combined transfer with forwarding:
  - Preload block 9 = all-ones.
  - blockwrite=1, blockread=1, wbaddr=3 with pattern A, blockaddr=3, instraddr=9 -> readblock=A, instrblock=all-ones, both in the same COMMIT.
- Busy-ignore: during WAIT pulse blockwrite=1 with wbaddr=7 and new data -> block 7 is unchanged on a later read; memready timing is unaffected.
- Aliasing (DEPTH=256): write pattern B to wbaddr=32'h105 -> read of blockaddr=5 returns B.
- Reset mid-operation: accept a write to block 2 (prior value C); assert rst_n during WAIT -> memready=1 immediately; a later read of block 2 returns C.
